// File: rtl/sa_dma_pkg.sv
// sa_dma_pkg: shared types and constants for the dma_read / dma_write pair.
// Holds the FSM state enum and AXI encodings used by both engines.
package sa_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } dma_state_e;

  localparam int         MAX_BURST     = 16;
  localparam int         PAGE_BYTES    = 4096;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

endpackage

// File: rtl/dma_read_skid.sv
// dma_read_skid: 2-entry skid buffer on the AXI R channel.
// Ports: i_clk/i_rst_n, i_valid/i_data/o_ready (in), o_valid/o_data/i_ready (out).
module dma_read_skid #(
  parameter int W = 35
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         r_rdy;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nx;

  assign w_push  = i_valid & r_rdy;
  assign w_pop   = (r_cnt != 2'd0) & i_ready;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_ready = r_rdy;

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_push && !w_pop) w_cnt_nx = r_cnt + 2'd1;
    if (!w_push && w_pop) w_cnt_nx = r_cnt - 2'd1;
  end

  // ready is registered: it drops only once the next count is full,
  // so a steady push+pop stream at count 1 never stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= w_cnt_nx;
      r_rdy <= (w_cnt_nx != 2'd2);
    end
  end

endmodule

// File: rtl/dma_read.sv
// dma_read: AXI4 read DMA streaming a byte range out as data beats.
// Ports: ACLK/ARESETN; i_start/i_base_addr/i_byte_len control;
//   o_busy/o_done/o_error status; o_data/o_valid/i_ready stream;
//   M_AXI_AR* address channel, M_AXI_R* data channel.
// Option: define DMA_READ_SKID_EN to put a 2-entry skid buffer on R.
module dma_read
  import sa_dma_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_USER_WIDTH = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          i_start,
  input  logic [31:0]                   i_base_addr,
  input  logic [31:0]                   i_byte_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_ARUSER,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_RUSER,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int LOG   = $clog2(BYTES);

  dma_state_e        r_state;
  dma_state_e        w_state_nx;

  logic              r_start_q;
  logic              r_start_qq;
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_remain;
  logic [4:0]        r_len;
  logic [4:0]        r_cnt;
  logic              r_error;

  logic              w_start_edge;
  logic [31:0]       w_beats;
  logic [12:0]       w_to4k;
  logic [4:0]        w_blen;
  logic              w_ar;
  logic              w_in_r;
  logic              w_fire;
  logic              w_last_beat;
  logic              w_out_valid;
  logic [DW-1:0]     w_out_data;
  logic [1:0]        w_out_resp;
  logic              w_out_last;
  logic              w_unused;

  assign w_unused = ^{M_AXI_RID, M_AXI_RUSER};

  assign w_start_edge = r_start_q & ~r_start_qq;
  assign w_beats = 32'(({1'b0, i_byte_len} + 33'(BYTES - 1)) >> LOG);

  // beats left before the 4 KB page ends; bursts never cross it
  assign w_to4k =
    (13'(PAGE_BYTES) - {1'b0, r_addr[11:0]}) >> LOG;

  always_comb begin
    w_blen = 5'(MAX_BURST);
    if (r_remain < 32'(MAX_BURST)) w_blen = r_remain[4:0];
    if ({19'd0, w_to4k} < {27'd0, w_blen}) w_blen = w_to4k[4:0];
  end

  assign w_ar        = (r_state == ST_AR);
  assign w_in_r      = (r_state == ST_R);
  assign w_fire      = w_out_valid & i_ready;
  assign w_last_beat = (r_cnt == r_len - 5'd1);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = w_ar ? 8'(w_blen - 5'd1) : 8'd0;
  assign M_AXI_ARSIZE  = 3'(LOG);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_DEFAULT;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARVALID = w_ar;

`ifdef DMA_READ_SKID_EN
  localparam int SKW = DW + 3;

  logic           w_sk_rdy;
  logic           w_sk_vld;
  logic [SKW-1:0] w_sk_q;

  dma_read_skid #(
    .W (SKW)
  ) u_skid (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_valid (w_in_r & M_AXI_RVALID),
    .i_data  ({M_AXI_RLAST, M_AXI_RRESP, M_AXI_RDATA}),
    .o_ready (w_sk_rdy),
    .o_valid (w_sk_vld),
    .o_data  (w_sk_q),
    .i_ready (w_in_r & i_ready)
  );

  assign M_AXI_RREADY = w_in_r & w_sk_rdy;
  assign w_out_valid  = w_in_r & w_sk_vld;
  assign {w_out_last, w_out_resp, w_out_data} = w_sk_q;
`else
  assign M_AXI_RREADY = w_in_r & i_ready;
  assign w_out_valid  = w_in_r & M_AXI_RVALID;
  assign w_out_data   = M_AXI_RDATA;
  assign w_out_resp   = M_AXI_RRESP;
  assign w_out_last   = M_AXI_RLAST;
`endif

  assign o_valid = w_out_valid;
  assign o_data  = w_in_r ? w_out_data : '0;
  assign o_busy  = w_ar | w_in_r;
  assign o_done  = (r_state == ST_DONE);
  assign o_error = r_error;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_edge)
          w_state_nx = (w_beats == 32'd0) ? ST_DONE : ST_AR;
      end
      ST_AR: begin
        if (M_AXI_ARREADY) w_state_nx = ST_R;
      end
      ST_R: begin
        if (w_fire && w_last_beat)
          w_state_nx = (r_remain == {27'd0, r_len}) ? ST_DONE : ST_AR;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_start_q  <= 1'b0;
      r_start_qq <= 1'b0;
      r_addr     <= '0;
      r_remain   <= 32'd0;
      r_len      <= 5'd0;
      r_cnt      <= 5'd0;
      r_error    <= 1'b0;
    end else begin
      r_start_q  <= i_start;
      r_start_qq <= r_start_q;
      if (r_state == ST_IDLE && w_start_edge) begin
        r_addr   <= AW'(i_base_addr & ~32'(BYTES - 1));
        r_remain <= w_beats;
        r_cnt    <= 5'd0;
        r_error  <= 1'b0;
      end
      if (w_ar && M_AXI_ARREADY) begin
        r_len <= w_blen;
        r_cnt <= 5'd0;
      end
      if (w_in_r && w_fire) begin
        // errors are sticky but the burst keeps draining
        if (w_out_resp != RESP_OKAY || w_out_last != w_last_beat)
          r_error <= 1'b1;
        if (w_last_beat) begin
          r_cnt    <= 5'd0;
          r_remain <= r_remain - {27'd0, r_len};
          r_addr   <= r_addr + (AW'(r_len) << LOG);
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

endmodule
